viterbi_hmm_engine: RTL

Parametrised log-domain Viterbi decoder for a discrete HMM with NS hidden states and NO observation symbols, decoding sequences of up to TMAX observations. It is the generalised successor of the fixed 3-state `viterbi_top`. It adds:
- valid/ready flow control on observations and on the decoded path;
- a streamed path output in time order;
- saturating arithmetic;
- a best-path score output;
- error signalling.

It sits between the observation source and the downstream path consumer; model tables are held externally and driven in as flat buses.

---
 rtl/viterbi_pkg.sv | 43 ++++
 rtl/viterbi_acs.sv | 43 ++++
 rtl/viterbi_hmm_engine.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the log-domain Viterbi engine.
package viterbi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_FINAL,
    ST_TRACE,
    ST_OUT
  } state_t;

  // Signed saturating add clamped to a w-bit two's-complement range.
  // Operands are passed sign-extended to 64 bits so the raw sum cannot wrap.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

  // Slice index of A[i][j] in the flat logA bus.
  function automatic int a_idx(input int i, input int j, input int ns);
    return i * ns + j;
  endfunction

  // Slice index of B[i][k] in the flat logB bus.
  function automatic int b_idx(input int i, input int k, input int no);
    return i * no + k;
  endfunction

  // Slice index of C[i] in the flat logC bus.
  function automatic int c_idx(input int i);
    return i;
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one destination state: best predecessor plus emission.
module viterbi_acs import viterbi_pkg::*; #(
  parameter int W  = 16,
  parameter int NS = 3,
  parameter int SW = 2
) (
  input  logic                 first,
  input  logic [NS*W-1:0]      delta_in,
  input  logic [NS*W-1:0]      a_col,
  input  logic signed [W-1:0]  b_val,
  input  logic signed [W-1:0]  c_val,
  output logic signed [W-1:0]  delta_out,
  output logic [SW-1:0]        bp_out
);

  logic signed [W-1:0] d [NS];
  logic signed [W-1:0] a [NS];
  logic signed [W-1:0] best;
  logic signed [W-1:0] cand;

  for (genvar i = 0; i < NS; i++) begin : g_unpack
    assign d[i] = delta_in[i*W +: W];
    assign a[i] = a_col[i*W +: W];
  end

  // Strict '>' keeps the lowest predecessor index on ties; the first
  // observation bypasses the transition term and starts from C[j].
  always_comb begin
    best   = W'(sat_add(64'(d[0]), 64'(a[0]), W));
    bp_out = '0;
    cand   = '0;
    for (int i = 1; i < NS; i++) begin
      cand = W'(sat_add(64'(d[i]), 64'(a[i]), W));
      if (cand > best) begin
        best   = cand;
        bp_out = SW'(i);
      end
    end
    if (first) delta_out = W'(sat_add(64'(c_val), 64'(b_val), W));
    else       delta_out = W'(sat_add(64'(best), 64'(b_val), W));
  end

endmodule

// File: rtl/viterbi_hmm_engine.sv
// Log-domain Viterbi decoder: forward ACS over streamed observations,
// final argmax, backpointer traceback, then time-ordered path streaming.
module viterbi_hmm_engine import viterbi_pkg::*; #(
  parameter int  W    = 16,
  parameter int  NS   = 3,
  parameter int  NO   = 3,
  parameter int  TMAX = 8,
  localparam int SW   = $clog2(NS),
  localparam int OW   = $clog2(NO),
  localparam int LW   = $clog2(TMAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LW-1:0]         length,
  input  logic [OW-1:0]         obs_in,
  input  logic                  obs_valid,
  output logic                  obs_ready,
  input  logic [NS*NS*W-1:0]    logA,
  input  logic [NS*NO*W-1:0]    logB,
  input  logic [NS*W-1:0]       logC,
  output logic [SW-1:0]         path_out,
  output logic                  path_valid,
  input  logic                  path_ready,
  output logic signed [W-1:0]   score,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(TMAX);

  state_t              state;
  logic [TW-1:0]       len_m1;
  logic [TW-1:0]       t;
  logic [TW-1:0]       k;
  logic [TW-1:0]       idx;
  logic signed [W-1:0] delta [NS];
  logic [SW-1:0]       bp [TMAX][NS];
  logic [SW-1:0]       path [TMAX];

  logic [NS*W-1:0]     delta_flat;
  logic signed [W-1:0] acs_delta [NS];
  logic [SW-1:0]       acs_bp [NS];
  logic signed [W-1:0] best_delta;
  logic [SW-1:0]       best_state;
  logic [SW-1:0]       trace_sym;
  logic                hs_obs;
  logic                hs_path;
  logic                len_ok;

  assign hs_obs    = obs_valid & obs_ready;
  assign hs_path   = path_valid & path_ready;
  assign len_ok    = (length != '0) && (length <= LW'(TMAX));
  assign trace_sym = bp[k][path[k]];

  for (genvar j = 0; j < NS; j++) begin : g_acs
    logic [NS*W-1:0]     a_col;
    logic signed [W-1:0] b_val;
    logic signed [W-1:0] c_val;

    assign delta_flat[j*W +: W] = delta[j];
    assign c_val = logC[c_idx(j)*W +: W];
    for (genvar i = 0; i < NS; i++) begin : g_col
      assign a_col[i*W +: W] = logA[a_idx(i, j, NS)*W +: W];
    end

    // Emission lookup for the current symbol as an explicit mux.
    always_comb begin
      b_val = '0;
      for (int s = 0; s < NO; s++)
        if (obs_in == OW'(s)) b_val = logB[b_idx(j, s, NO)*W +: W];
    end

    viterbi_acs #(.W(W), .NS(NS), .SW(SW)) u_acs (
      .first     (t == '0),
      .delta_in  (delta_flat),
      .a_col     (a_col),
      .b_val     (b_val),
      .c_val     (c_val),
      .delta_out (acs_delta[j]),
      .bp_out    (acs_bp[j])
    );
  end

  // Best final state, lowest index wins ties.
  always_comb begin
    best_state = '0;
    best_delta = delta[0];
    for (int j = 1; j < NS; j++) begin
      if (delta[j] > best_delta) begin
        best_delta = delta[j];
        best_state = SW'(j);
      end
    end
  end

  // Backpointer and path storage; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == ST_FWD && hs_obs && t != '0)
      for (int j = 0; j < NS; j++) bp[t][j] <= acs_bp[j];
    if (state == ST_FINAL) path[len_m1] <= best_state;
    if (state == ST_TRACE) path[k - TW'(1)] <= trace_sym;
  end

  // Control FSM with registered outputs, delta and score.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len_m1     <= '0;
      t          <= '0;
      k          <= '0;
      idx        <= '0;
      score      <= '0;
      obs_ready  <= 1'b0;
      path_valid <= 1'b0;
      path_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      for (int j = 0; j < NS; j++) delta[j] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_m1    <= TW'(length - LW'(1));
              t         <= '0;
              obs_ready <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_FWD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_FWD: begin
          if (hs_obs) begin
            for (int j = 0; j < NS; j++) delta[j] <= acs_delta[j];
            t <= t + TW'(1);
            if (t == len_m1) begin
              obs_ready <= 1'b0;
              state     <= ST_FINAL;
            end
          end
        end
        ST_FINAL: begin
          score <= best_delta;
          k     <= len_m1;
          if (len_m1 != '0) begin
            state <= ST_TRACE;
          end else begin
            path_out   <= best_state;
            path_valid <= 1'b1;
            idx        <= '0;
            state      <= ST_OUT;
          end
        end
        ST_TRACE: begin
          k <= k - TW'(1);
          if (k == TW'(1)) begin
            path_out   <= trace_sym;
            path_valid <= 1'b1;
            idx        <= '0;
            state      <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (hs_path) begin
            if (idx == len_m1) begin
              path_valid <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              idx      <= idx + TW'(1);
              path_out <= path[idx + TW'(1)];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
